// File: rtl/hazard_controller_pkg.sv
// -----------------------------------------------------------------------------
// hazard_controller_pkg
// Shared pipeline definitions for the hazard controller and its mult/div
// sequencer.
//   fwd_sel_e       : ALU operand source select (register file / writeback /
//                     memory)
//   muldiv_state_e  : state encoding of the mult/div sequencer
//   muldiv_load     : down-counter preload for a given operation type
// -----------------------------------------------------------------------------
package hazard_controller_pkg;

  // Width of the execute-stage forward selects
  localparam int FWD_W = 2;

  // Execute-stage operand source. The memory stage holds the younger result,
  // so it is preferred over writeback whenever both match.
  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Mult/div sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // The counter is loaded with latency-1 because the BUSY state is also
  // occupied on the cycle the counter reads zero.
  function automatic int muldiv_load(input logic is_div,
                                     input int   mult_cycles,
                                     input int   div_cycles);
    return is_div ? (div_cycles - 1) : (mult_cycles - 1);
  endfunction

endpackage

// File: rtl/hazard_controller_muldiv.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Tracks an outstanding multiply or divide. A start accepted in IDLE moves to
// BUSY with a down-counter preloaded to latency-1; when the counter reaches
// zero the sequencer spends one cycle in DONE, raising hilo_write, then
// returns to IDLE.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : decode stage issues a mult/div
//   stall             : decode stage is stalled (start not accepted)
//   is_div            : the issued operation is a divide
//   busy              : registered, high in BUSY and DONE
//   hilo_write        : registered, high only in DONE
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import hazard_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stall,
  input  logic is_div,
  output logic busy,
  output logic hilo_write
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(muldiv_load(1'b0, MULT_CYCLES, DIV_CYCLES));
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(muldiv_load(1'b1, MULT_CYCLES, DIV_CYCLES));

  muldiv_state_e    state;
  logic [CNT_W-1:0] count;

  // Single sequential block holding the state, the down-counter and the
  // registered status outputs. busy and hilo_write are set on the same edge
  // that enters the state they describe, so they never glitch. A start seen
  // outside IDLE is ignored, which is what keeps a start-while-busy from
  // restarting the counter. Reset mid-operation simply returns to IDLE, so the
  // abandoned operation never produces a hilo_write pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      hilo_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stall) begin
            state <= BUSY;
            count <= is_div ? DIV_LOAD : MULT_LOAD;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state      <= DONE;
            hilo_write <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          hilo_write <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          count      <= '0;
          busy       <= 1'b0;
          hilo_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Pipeline hazard unit for a five-stage MIPS-style core with a multi-cycle
// mult/div unit.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   branch_decode, muldiv_*_decode,
//   hilo_read_decode              : decode-stage control
//   rs/rt_decode, rs/rt_execute,
//   write_register_{execute,memory,writeback} : register addresses
//   memory_to_register_*, register_write_*, jump_execute : pipeline flags
//   stall_fetch, stall_decode,
//   flush_decode, flush_execute   : pipeline control (combinational)
//   forward_{a,b}_decode          : branch comparator forward from memory
//   forward_{a,b}_execute         : ALU operand select (fwd_sel_e encoding)
//   muldiv_busy, hilo_write       : mult/div status (registered)
//   stall_count, stall_count_clear: saturating stalled-cycle counter + clear
// -----------------------------------------------------------------------------
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int COUNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  branch_decode,
  input  logic                  muldiv_start_decode,
  input  logic                  muldiv_is_div_decode,
  input  logic                  hilo_read_decode,
  input  logic [REG_ADDR_W-1:0] rs_decode,
  input  logic [REG_ADDR_W-1:0] rt_decode,
  input  logic [REG_ADDR_W-1:0] rs_execute,
  input  logic [REG_ADDR_W-1:0] rt_execute,
  input  logic [REG_ADDR_W-1:0] write_register_execute,
  input  logic [REG_ADDR_W-1:0] write_register_memory,
  input  logic [REG_ADDR_W-1:0] write_register_writeback,
  input  logic                  memory_to_register_execute,
  input  logic                  register_write_execute,
  input  logic                  memory_to_register_memory,
  input  logic                  register_write_memory,
  input  logic                  register_write_writeback,
  input  logic                  jump_execute,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  flush_decode,
  output logic                  flush_execute,
  output logic                  forward_a_decode,
  output logic                  forward_b_decode,
  output logic [FWD_W-1:0]      forward_a_execute,
  output logic [FWD_W-1:0]      forward_b_execute,
  output logic                  muldiv_busy,
  output logic                  hilo_write,
  output logic [COUNT_W-1:0]    stall_count,
  input  logic                  stall_count_clear
);

  logic lw_stall;
  logic branch_stall;
  logic hilo_stall;
  logic stall_any;

  // A source hits a producing stage only if it is not $zero, the addresses
  // match and that stage will actually write the register file.
  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst,
                                   input logic                  we);
    return (src != '0) && (src == dst) && we;
  endfunction

  // Memory is checked first: it carries the most recent value of the
  // register, so it must win over an older writeback result.
  function automatic logic [FWD_W-1:0] exec_fwd(input logic [REG_ADDR_W-1:0] src);
    if (src_hit(src, write_register_memory, register_write_memory))
      return FWD_MEM;
    else if (src_hit(src, write_register_writeback, register_write_writeback))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Operand forwarding for the ALU and for the decode-stage branch
  // comparator. The comparator only forwards from memory; a load still in
  // execute or memory is handled by stalling instead.
  always_comb begin
    forward_a_execute = exec_fwd(rs_execute);
    forward_b_execute = exec_fwd(rt_execute);
    forward_a_decode  = src_hit(rs_decode, write_register_memory, register_write_memory);
    forward_b_decode  = src_hit(rt_decode, write_register_memory, register_write_memory);
  end

  // Hazard detection. A load in execute stalls a dependent instruction in
  // decode (its data only exists after memory). A branch stalls while either
  // source is still being computed in execute, or is a load sitting in memory
  // whose value is not yet forwardable. The mult/div unit stalls any HI/LO
  // read or a second start while an operation is in flight.
  always_comb begin
    lw_stall = memory_to_register_execute && (rt_execute != '0) &&
               ((rs_decode == rt_execute) || (rt_decode == rt_execute));

    branch_stall = branch_decode &&
                   (src_hit(rs_decode, write_register_execute, register_write_execute) ||
                    src_hit(rs_decode, write_register_memory,  memory_to_register_memory) ||
                    src_hit(rt_decode, write_register_execute, register_write_execute) ||
                    src_hit(rt_decode, write_register_memory,  memory_to_register_memory));

    hilo_stall = muldiv_busy && (hilo_read_decode || muldiv_start_decode);

    stall_any = lw_stall || branch_stall || hilo_stall;
  end

  // Pipeline control. The instruction held in decode must not be lost, so a
  // stall suppresses the jump flush of decode; execute receives a bubble.
  always_comb begin
    stall_fetch   = stall_any;
    stall_decode  = stall_any;
    flush_execute = stall_any;
    flush_decode  = jump_execute && !stall_any;
  end

  muldiv_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_muldiv_sequencer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (muldiv_start_decode),
    .stall      (stall_any),
    .is_div     (muldiv_is_div_decode),
    .busy       (muldiv_busy),
    .hilo_write (hilo_write)
  );

  // Stalled-cycle performance counter. Clear has priority over counting, and
  // the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall_count_clear) begin
      stall_count <= '0;
    end else if (stall_any && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Self-checking bench for hazard_controller: a table of combinational
// vectors, hand-written mult/div, stall, reset and counter sequences, then
// randomized cycles checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int AW    = 5;
  localparam int MULT  = 4;
  localparam int DIV   = 32;
  localparam int CW    = 4;
  localparam int NVEC  = 13;
  localparam int NRAND = 400;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          branch_decode, muldiv_start_decode, muldiv_is_div_decode, hilo_read_decode;
  logic [AW-1:0] rs_decode, rt_decode, rs_execute, rt_execute;
  logic [AW-1:0] write_register_execute, write_register_memory, write_register_writeback;
  logic          memory_to_register_execute, register_write_execute;
  logic          memory_to_register_memory, register_write_memory;
  logic          register_write_writeback, jump_execute;
  logic          stall_fetch, stall_decode, flush_decode, flush_execute;
  logic          forward_a_decode, forward_b_decode;
  logic [1:0]    forward_a_execute, forward_b_execute;
  logic          muldiv_busy, hilo_write;
  logic [CW-1:0] stall_count;
  logic          stall_count_clear;

  int total_checks = 0;
  int bad_checks   = 0;

  hazard_controller #(
    .REG_ADDR_W  (AW),
    .MULT_CYCLES (MULT),
    .DIV_CYCLES  (DIV),
    .COUNT_W     (CW)
  ) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .branch_decode              (branch_decode),
    .muldiv_start_decode        (muldiv_start_decode),
    .muldiv_is_div_decode       (muldiv_is_div_decode),
    .hilo_read_decode           (hilo_read_decode),
    .rs_decode                  (rs_decode),
    .rt_decode                  (rt_decode),
    .rs_execute                 (rs_execute),
    .rt_execute                 (rt_execute),
    .write_register_execute     (write_register_execute),
    .write_register_memory      (write_register_memory),
    .write_register_writeback   (write_register_writeback),
    .memory_to_register_execute (memory_to_register_execute),
    .register_write_execute     (register_write_execute),
    .memory_to_register_memory  (memory_to_register_memory),
    .register_write_memory      (register_write_memory),
    .register_write_writeback   (register_write_writeback),
    .jump_execute               (jump_execute),
    .stall_fetch                (stall_fetch),
    .stall_decode               (stall_decode),
    .flush_decode               (flush_decode),
    .flush_execute              (flush_execute),
    .forward_a_decode           (forward_a_decode),
    .forward_b_decode           (forward_b_decode),
    .forward_a_execute          (forward_a_execute),
    .forward_b_execute          (forward_b_execute),
    .muldiv_busy                (muldiv_busy),
    .hilo_write                 (hilo_write),
    .stall_count                (stall_count),
    .stall_count_clear          (stall_count_clear)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Watchdog so a stuck sequence can never hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic          branch, m2r_e, rw_e, m2r_m, rw_m, rw_w, jump;
    logic [1:0]    fa_e, fb_e;
    logic          fa_d, fb_d, stall, flush_d;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic vec_t mkVec(
      input int rs_d, input int rt_d, input int rs_e, input int rt_e,
      input int wr_e, input int wr_m, input int wr_w,
      input bit branch, input bit m2r_e, input bit rw_e, input bit m2r_m,
      input bit rw_m, input bit rw_w, input bit jump,
      input int fa_e, input int fb_e, input bit fa_d, input bit fb_d,
      input bit stall, input bit flush_d);
    vec_t v;
    v.rs_d = AW'(rs_d); v.rt_d = AW'(rt_d); v.rs_e = AW'(rs_e); v.rt_e = AW'(rt_e);
    v.wr_e = AW'(wr_e); v.wr_m = AW'(wr_m); v.wr_w = AW'(wr_w);
    v.branch = branch; v.m2r_e = m2r_e; v.rw_e = rw_e; v.m2r_m = m2r_m;
    v.rw_m = rw_m; v.rw_w = rw_w; v.jump = jump;
    v.fa_e = 2'(fa_e); v.fb_e = 2'(fb_e); v.fa_d = fa_d; v.fb_d = fb_d;
    v.stall = stall; v.flush_d = flush_d;
    return v;
  endfunction

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, actual, expected);
    end
  endtask

  // Quiet all decode/pipeline inputs (no hazards, no mult/div activity)
  task automatic idleInputs();
    branch_decode = 0; muldiv_start_decode = 0; muldiv_is_div_decode = 0;
    hilo_read_decode = 0; rs_decode = 0; rt_decode = 0; rs_execute = 0;
    rt_execute = 0; write_register_execute = 0; write_register_memory = 0;
    write_register_writeback = 0; memory_to_register_execute = 0;
    register_write_execute = 0; memory_to_register_memory = 0;
    register_write_memory = 0; register_write_writeback = 0;
    jump_execute = 0; stall_count_clear = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    idleInputs();
    rs_decode = v.rs_d; rt_decode = v.rt_d; rs_execute = v.rs_e; rt_execute = v.rt_e;
    write_register_execute = v.wr_e; write_register_memory = v.wr_m;
    write_register_writeback = v.wr_w; branch_decode = v.branch;
    memory_to_register_execute = v.m2r_e; register_write_execute = v.rw_e;
    memory_to_register_memory = v.m2r_m; register_write_memory = v.rw_m;
    register_write_writeback = v.rw_w; jump_execute = v.jump;
  endtask

  // Launch one mult/div and measure how long busy stays up and where the
  // single hilo_write pulse lands
  task automatic runMuldiv(input bit is_div, input int exp_busy, input string tag);
    int busy_cycles = 0;
    int hilo_at = 0;
    int hilo_pulses = 0;
    @(negedge clk);
    idleInputs();
    muldiv_start_decode = 1; muldiv_is_div_decode = is_div;
    @(negedge clk);
    muldiv_start_decode = 0; muldiv_is_div_decode = 0;
    for (int i = 0; i < 100; i++) begin
      if (!muldiv_busy) break;
      busy_cycles++;
      if (hilo_write) begin
        hilo_pulses++;
        hilo_at = busy_cycles;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, busy_cycles, exp_busy);
    checkOutput({tag, "_hilo_cycle"}, hilo_at, exp_busy);
    checkOutput({tag, "_hilo_pulses"}, hilo_pulses, 1);
  endtask

  // Reference rules, straight from the hazard definitions
  function automatic bit refHit(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic we);
    return (src != 0) && (src == dst) && (we == 1'b1);
  endfunction

  function automatic int refFwdExec(input logic [AW-1:0] src);
    if (refHit(src, write_register_memory, register_write_memory)) return 2;
    if (refHit(src, write_register_writeback, register_write_writeback)) return 1;
    return 0;
  endfunction

  int  ref_busy_left;
  int  ref_count;

  initial begin
    bit ref_lw, ref_br, ref_hs, ref_stall, saw_hilo, saw_busy;
    reset_n = 0;
    idleInputs();

    // Reset state
    #3;
    checkOutput("reset_busy", muldiv_busy, 0);
    checkOutput("reset_hilo", hilo_write, 0);
    checkOutput("reset_count", stall_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;

    // Combinational table
    vecs[0]  = mkVec(0,0,3,0,0,3,3,  0,0,0,0,1,1,0,  2,0,0,0,0,0);
    vecs[1]  = mkVec(0,0,0,0,0,3,3,  0,0,0,0,1,1,0,  0,0,0,0,0,0);
    vecs[2]  = mkVec(0,0,4,4,0,4,4,  0,0,0,0,0,1,0,  1,1,0,0,0,0);
    vecs[3]  = mkVec(6,7,6,7,0,7,6,  0,0,0,0,1,1,0,  1,2,0,1,0,0);
    vecs[4]  = mkVec(5,0,0,5,0,0,0,  0,1,0,0,0,0,1,  0,0,0,0,1,0);
    vecs[5]  = mkVec(5,0,0,0,0,0,0,  0,1,0,0,0,0,1,  0,0,0,0,0,1);
    vecs[6]  = mkVec(0,9,0,9,0,0,0,  0,1,0,0,0,0,0,  0,0,0,0,1,0);
    vecs[7]  = mkVec(8,0,0,0,8,0,0,  1,0,1,0,0,0,0,  0,0,0,0,1,0);
    vecs[8]  = mkVec(8,0,0,0,8,0,0,  1,0,0,0,0,0,0,  0,0,0,0,0,0);
    vecs[9]  = mkVec(0,10,0,0,0,10,0, 1,0,0,1,1,0,0, 0,0,0,1,1,0);
    vecs[10] = mkVec(0,10,0,0,0,10,0, 1,0,0,0,1,0,0, 0,0,0,1,0,0);
    vecs[11] = mkVec(0,0,0,0,0,0,0,  1,0,1,0,1,0,0,  0,0,0,0,0,0);
    vecs[12] = mkVec(8,0,0,0,8,0,0,  0,0,1,0,0,0,1,  0,0,0,0,0,1);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_fa_e", i), forward_a_execute, vecs[i].fa_e);
      checkOutput($sformatf("v%0d_fb_e", i), forward_b_execute, vecs[i].fb_e);
      checkOutput($sformatf("v%0d_fa_d", i), forward_a_decode, vecs[i].fa_d);
      checkOutput($sformatf("v%0d_fb_d", i), forward_b_decode, vecs[i].fb_d);
      checkOutput($sformatf("v%0d_stall_d", i), stall_decode, vecs[i].stall);
      checkOutput($sformatf("v%0d_stall_f", i), stall_fetch, vecs[i].stall);
      checkOutput($sformatf("v%0d_flush_e", i), flush_execute, vecs[i].stall);
      checkOutput($sformatf("v%0d_flush_d", i), flush_decode, vecs[i].flush_d);
    end

    // Mult and div latency
    runMuldiv(1'b0, MULT + 1, "mult");
    runMuldiv(1'b1, DIV + 1, "div");

    // HI/LO read while busy, with a simultaneous jump
    @(negedge clk);
    idleInputs();
    muldiv_start_decode = 1;
    @(negedge clk);
    muldiv_start_decode = 0; hilo_read_decode = 1; jump_execute = 1;
    for (int c = 1; c <= MULT + 2; c++) begin
      #1;
      checkOutput($sformatf("hilo_rd_c%0d_stall", c), stall_decode, (c <= MULT + 1) ? 1 : 0);
      checkOutput($sformatf("hilo_rd_c%0d_flush_d", c), flush_decode, (c <= MULT + 1) ? 0 : 1);
      @(negedge clk);
    end

    // Reset in the middle of a divide
    idleInputs();
    muldiv_start_decode = 1; muldiv_is_div_decode = 1;
    @(negedge clk);
    idleInputs();
    repeat (10) @(negedge clk);
    checkOutput("div_mid_busy", muldiv_busy, 1);
    #2 reset_n = 0;
    #1;
    checkOutput("rst_mid_busy", muldiv_busy, 0);
    checkOutput("rst_mid_hilo", hilo_write, 0);
    checkOutput("rst_mid_count", stall_count, 0);
    saw_hilo = 0; saw_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (hilo_write) saw_hilo = 1;
      if (muldiv_busy) saw_busy = 1;
    end
    reset_n = 1;
    for (int c = 0; c < DIV + 8; c++) begin
      @(negedge clk);
      if (hilo_write) saw_hilo = 1;
      if (muldiv_busy) saw_busy = 1;
    end
    checkOutput("rst_no_hilo", saw_hilo, 0);
    checkOutput("rst_stay_idle", saw_busy, 0);

    // Stall counter saturation and clear priority
    stall_count_clear = 1;
    @(negedge clk);
    stall_count_clear = 0;
    checkOutput("cnt_cleared", stall_count, 0);
    memory_to_register_execute = 1; rt_execute = 5; rs_decode = 5;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) checkOutput("cnt_after3", stall_count, 3);
    end
    checkOutput("cnt_saturated", stall_count, (1 << CW) - 1);
    stall_count_clear = 1;
    @(negedge clk);
    checkOutput("cnt_clear_wins", stall_count, 0);
    stall_count_clear = 0;
    @(negedge clk);
    checkOutput("cnt_resume", stall_count, 1);

    // Randomized cycles against the behavioural model
    idleInputs();
    stall_count_clear = 1;
    @(negedge clk);
    ref_busy_left = 0;
    ref_count = 0;
    for (int n = 0; n < NRAND; n++) begin
      @(negedge clk);
      rs_decode = AW'($urandom_range(0, 3));
      rt_decode = AW'($urandom_range(0, 3));
      rs_execute = AW'($urandom_range(0, 3));
      rt_execute = AW'($urandom_range(0, 3));
      write_register_execute = AW'($urandom_range(0, 3));
      write_register_memory = AW'($urandom_range(0, 3));
      write_register_writeback = AW'($urandom_range(0, 3));
      branch_decode = ($urandom_range(0, 3) == 0);
      memory_to_register_execute = ($urandom_range(0, 3) == 0);
      register_write_execute = $urandom_range(0, 1) == 1;
      memory_to_register_memory = $urandom_range(0, 1) == 1;
      register_write_memory = $urandom_range(0, 1) == 1;
      register_write_writeback = $urandom_range(0, 1) == 1;
      jump_execute = $urandom_range(0, 1) == 1;
      muldiv_start_decode = ($urandom_range(0, 3) == 0);
      muldiv_is_div_decode = ($urandom_range(0, 3) == 0);
      hilo_read_decode = ($urandom_range(0, 3) == 0);
      stall_count_clear = ($urandom_range(0, 15) == 0);
      #1;
      ref_lw = memory_to_register_execute && (rt_execute != 0) &&
               (rs_decode == rt_execute || rt_decode == rt_execute);
      ref_br = branch_decode &&
               (refHit(rs_decode, write_register_execute, register_write_execute) ||
                refHit(rt_decode, write_register_execute, register_write_execute) ||
                refHit(rs_decode, write_register_memory, memory_to_register_memory) ||
                refHit(rt_decode, write_register_memory, memory_to_register_memory));
      ref_hs = (ref_busy_left > 0) && (hilo_read_decode || muldiv_start_decode);
      ref_stall = ref_lw || ref_br || ref_hs;
      checkOutput("rnd_fa_e", forward_a_execute, refFwdExec(rs_execute));
      checkOutput("rnd_fb_e", forward_b_execute, refFwdExec(rt_execute));
      checkOutput("rnd_fa_d", forward_a_decode,
                  refHit(rs_decode, write_register_memory, register_write_memory));
      checkOutput("rnd_fb_d", forward_b_decode,
                  refHit(rt_decode, write_register_memory, register_write_memory));
      checkOutput("rnd_stall_d", stall_decode, ref_stall);
      checkOutput("rnd_stall_f", stall_fetch, ref_stall);
      checkOutput("rnd_flush_e", flush_execute, ref_stall);
      checkOutput("rnd_flush_d", flush_decode, jump_execute && !ref_stall);
      checkOutput("rnd_busy", muldiv_busy, ref_busy_left > 0);
      checkOutput("rnd_hilo", hilo_write, ref_busy_left == 1);
      checkOutput("rnd_count", stall_count, ref_count);
      // Next-state of the model for the coming edge
      if (ref_busy_left > 0)
        ref_busy_left--;
      else if (muldiv_start_decode && !ref_stall)
        ref_busy_left = (muldiv_is_div_decode ? DIV : MULT) + 1;
      if (stall_count_clear)
        ref_count = 0;
      else if (ref_stall && ref_count < (1 << CW) - 1)
        ref_count++;
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL take parameters: REG_ADDR_W (default 5) = register address width; MULT_CYCLES (default 4) = MULT latency; DIV_CYCLES (default 32) = DIV latency; COUNT_W (default 16) = stall counter width.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- branch_decode, muldiv_start_decode, muldiv_is_div_decode, hilo_read_decode  in  1  decode-stage control.
- rs_decode, rt_decode, rs_execute, rt_execute, write_register_execute, write_register_memory, write_register_writeback  in  REG_ADDR_W  register addresses.
- memory_to_register_execute, register_write_execute, memory_to_register_memory, register_write_memory, register_write_writeback, jump_execute  in  1  pipeline flags.
- stall_fetch, stall_decode, flush_decode, flush_execute  out  1  pipeline control.
- forward_a_decode, forward_b_decode  out  1  branch-compare forward from memory.
- forward_a_execute, forward_b_execute  out  2  ALU operand select: 00 register file, 01 writeback, 10 memory.
- muldiv_busy, hilo_write  out  1  mult/div unit status and HI/LO write strobe.
- stall_count  out  COUNT_W  saturating count of stalled cycles.
- stall_count_clear  in  1  synchronous clear of stall_count.

Function
REQ-003 forward_a_execute SHALL be 10 when rs_execute!=0, equals write_register_memory and register_write_memory; else 01 on the same match against writeback; else 00. forward_b_execute uses rt_execute identically; memory beats writeback.
REQ-004 forward_a_decode/forward_b_decode SHALL be 1 when rs_decode/rt_decode is nonzero, equals write_register_memory and register_write_memory.
REQ-005 lwstall SHALL be memory_to_register_execute and rt_execute!=0 and (rs_decode==rt_execute or rt_decode==rt_execute).
REQ-006 branchstall SHALL be branch_decode and a nonzero source of rs_decode/rt_decode matching either (write_register_execute with register_write_execute) or (write_register_memory with memory_to_register_memory).
REQ-007 The mult/div FSM SHALL have states IDLE, BUSY, DONE; reset state IDLE, down-counter 0.
REQ-008 IDLE->BUSY SHALL occur when muldiv_start_decode=1 and stall_decode=0; counter loads DIV_CYCLES-1 when muldiv_is_div_decode=1, else MULT_CYCLES-1.
REQ-009 BUSY SHALL decrement each cycle, go to DONE on the cycle the counter reads 0; DONE->IDLE unconditionally after one cycle.
REQ-010 muldiv_busy SHALL be 1 in BUSY and DONE; hilo_write SHALL be 1 only in DONE.
REQ-011 hilostall SHALL be muldiv_busy and (hilo_read_decode or muldiv_start_decode); a start while busy never restarts the counter.
REQ-012 stall_fetch and stall_decode SHALL equal lwstall or branchstall or hilostall; flush_execute SHALL equal the same term.
REQ-013 flush_decode SHALL equal jump_execute and not stall_decode; a simultaneous stall takes priority over the jump flush.
REQ-014 stall_count SHALL increment by 1 on every cycle stall_decode=1, saturate at all-ones, and go to 0 when stall_count_clear=1; clear wins over increment in the same cycle.
REQ-015 All outputs other than FSM- and counter-derived ones SHALL be combinational, with zero-cycle latency.

Reset
REQ-016 While reset_n=0: FSM IDLE, down-counter 0, stall_count 0, muldiv_busy 0, hilo_write 0, independent of clk.
REQ-017 Reset asserted mid-BUSY SHALL abandon the operation with no hilo_write pulse.

Structure
REQ-018 The FSM state enum and forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) SHALL live in a shared pipeline package.
REQ-019 The mult/div FSM and down-counter SHALL be one sub-module, muldiv_sequencer; the hazard logic stays in the top level.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- rs_execute=3, write_register_memory=3 with register_write_memory=1, write_register_writeback=3 with register_write_writeback=1 -> forward_a_execute=10. Repeat with rs_execute=0 -> 00.
- memory_to_register_execute=1, rt_execute=5, rs_decode=5 -> stall_fetch=stall_decode=flush_execute=1. Repeat with rt_execute=0 -> all 0.
- MULT start in IDLE -> muldiv_busy=1 for 5 cycles with hilo_write in the 5th. A DIV start -> 33 busy cycles.
- hilo_read_decode=1 during BUSY -> stall_decode=1 until DONE passes; jump_execute in the same cycle -> flush_decode=0.
- reset_n dropped mid-DIV -> immediate IDLE, muldiv_busy=0, no hilo_write.
- Force continuous stall with COUNT_W=4 -> stall_count reaches 15 and holds; stall_count_clear -> 0 next edge.
